byte_fifo_mem: RTL and testbench

//  Byte store fed by the key-edge/switch capture stage: each write pulse pushes the sampled switch byte.

---
 rtl/byte_fifo_pkg.sv | 15 +
 rtl/byte_fifo_ram.sv | 38 +++
 rtl/byte_fifo_mem.sv | 132 +++++++++++++
 tb/tb_byte_fifo_mem.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/byte_fifo_pkg.sv
// Shared constants and types for the byte FIFO used between the
// key-edge/switch capture stage and the hex-to-segment display stage.
//   FIFO_DW     data width in bits
//   FIFO_DEPTH  number of entries (power of two, >= 2)
//   FIFO_AW     pointer width, $clog2(FIFO_DEPTH)
package byte_fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  typedef logic [FIFO_DW-1:0] fifo_byte_t;
  typedef logic [FIFO_AW:0]   fifo_cnt_t;

endpackage

// File: rtl/byte_fifo_ram.sv
// DEPTH x DW register array backing the byte FIFO.
// Ports:
//   clk    in   system clock, write on rising edge
//   rst_n  in   asynchronous active-low reset, clears every entry to 0
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read of mem[raddr]
module byte_fifo_ram
  import byte_fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/byte_fifo_mem.sv
// Byte FIFO: write pulses push the sampled switch byte, read pulses pop the
// oldest byte. Head byte (show-ahead), fill count and status flags feed the
// display stage.
// Configuration macro: FIFO_OVERWRITE_EN
//   undefined - a push while full is dropped
//   defined   - a push while full overwrites the oldest entry
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   wr_pulse   in   one-cycle push strobe
//   wr_data    in   byte to push, sampled with wr_pulse
//   rd_pulse   in   one-cycle pop strobe
//   clr_pulse  in   one-cycle flush strobe (wins over push/pop)
//   rd_data    out  oldest entry, 0 when empty
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   ovf        out  sticky: push attempted while full (without a pop)
//   udf        out  sticky: pop attempted while empty
module byte_fifo_mem
  import byte_fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_pulse,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_pulse,
  input  logic          clr_pulse,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] ram_rdata;

  logic do_wr, adv_rd, cnt_inc, cnt_dec, set_ovf, set_udf;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Decode the per-cycle action; clr_pulse suppresses everything.
  always_comb begin
    do_wr   = 1'b0;
    adv_rd  = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (!clr_pulse) begin
      if (wr_pulse && rd_pulse) begin
        if (empty) begin
          // Nothing to pop yet: the write lands, the pop is flagged.
          do_wr   = 1'b1;
          cnt_inc = 1'b1;
          set_udf = 1'b1;
        end else begin
          // Includes the full case: the pop frees the slot being written.
          do_wr  = 1'b1;
          adv_rd = 1'b1;
        end
      end else if (wr_pulse) begin
        if (!full) begin
          do_wr   = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          set_ovf = 1'b1;
`ifdef FIFO_OVERWRITE_EN
          // wr_ptr == rd_ptr when full, so this replaces the oldest entry.
          do_wr  = 1'b1;
          adv_rd = 1'b1;
`endif
        end
      end else if (rd_pulse) begin
        if (!empty) begin
          adv_rd  = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          set_udf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr_pulse) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_wr)   wr_ptr <= wr_ptr + AW'(1);
      if (adv_rd)  rd_ptr <= rd_ptr + AW'(1);
      if (cnt_inc) count  <= count + (AW+1)'(1);
      if (cnt_dec) count  <= count - (AW+1)'(1);
      if (set_ovf) ovf    <= 1'b1;
      if (set_udf) udf    <= 1'b1;
    end
  end

  byte_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_data = empty ? '0 : ram_rdata;

endmodule

// File: tb/tb_byte_fifo_mem.sv
// Directed self-checking bench for byte_fifo_mem (DW=8, DEPTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_byte_fifo_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_pulse = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_pulse = 1'b0;
  logic       clr_pulse = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full, empty, ovf, udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_fifo_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_pulse  (wr_pulse),
    .wr_data   (wr_data),
    .rd_pulse  (rd_pulse),
    .clr_pulse (clr_pulse),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .udf       (udf)
  );

  // Drive one cycle of strobes starting at a falling edge, then release them.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_pulse  = w;
    wr_data   = d;
    rd_pulse  = r;
    clr_pulse = c;
    @(negedge clk);
    wr_pulse  = 1'b0;
    rd_pulse  = 1'b0;
    clr_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (rd_data !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_data got rd=%h ovf=%b udf=%b exp 00/0/0", rd_data, ovf, udf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push_pop();
    step(1, 8'h12, 0, 0);
    step(1, 8'h34, 0, 0);
    step(1, 8'h56, 0, 0);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL push3_count got %0d exp 3", count); end
    checks++; if (rd_data !== 8'h12) begin errors++; $display("FAIL push3_head got %h exp 12", rd_data); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL push3_flags got empty=%b full=%b exp 0/0", empty, full); end
    step(0, 8'h00, 1, 0);
    checks++; if (rd_data !== 8'h34 || count !== 5'd2) begin errors++; $display("FAIL pop1 got rd=%h cnt=%0d exp 34/2", rd_data, count); end
    step(0, 8'h00, 1, 0);
    checks++; if (rd_data !== 8'h56) begin errors++; $display("FAIL pop2_head got %h exp 56", rd_data); end
    step(0, 8'h00, 1, 0);
    checks++; if (empty !== 1'b1 || rd_data !== 8'h00 || count !== 5'd0) begin errors++; $display("FAIL pop3 got empty=%b rd=%h cnt=%0d exp 1/00/0", empty, rd_data, count); end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL pop3_udf got %b exp 0", udf); end
  endtask

  task automatic test_overflow();
    logic [7:0] last;
    logic [7:0] exp_head;
    logic [7:0] exp_last;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    checks++; if (full !== 1'b1 || rd_data !== 8'h00 || count !== 5'd16) begin errors++; $display("FAIL fill16 got full=%b rd=%h cnt=%0d exp 1/00/16", full, rd_data, count); end
    step(1, 8'hAA, 0, 0);
`ifdef FIFO_OVERWRITE_EN
    exp_head = 8'h01;
    exp_last = 8'hAA;
`else
    exp_head = 8'h00;
    exp_last = 8'h0F;
`endif
    checks++; if (ovf !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/16", ovf, count); end
    checks++; if (rd_data !== exp_head) begin errors++; $display("FAIL ovf_head got %h exp %h", rd_data, exp_head); end
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rd_data;
      step(0, 8'h00, 1, 0);
    end
    checks++; if (last !== exp_last) begin errors++; $display("FAIL ovf_last_pop got %h exp %h", last, exp_last); end
    checks++; if (empty !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_drain got empty=%b ovf=%b exp 1/1", empty, ovf); end
  endtask

  task automatic test_underflow();
    step(0, 8'h00, 1, 0);
    checks++; if (udf !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL udf_set got udf=%b cnt=%0d exp 1/0", udf, count); end
    step(1, 8'h5C, 1, 0);
    checks++; if (count !== 5'd1 || rd_data !== 8'h5C || udf !== 1'b1) begin errors++; $display("FAIL udf_pushpop got cnt=%0d rd=%h udf=%b exp 1/5c/1", count, rd_data, udf); end
    step(0, 8'h00, 1, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL udf_drain got empty=%b exp 1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    step(0, 8'h00, 0, 1);
    checks++; if (ovf !== 1'b0 || udf !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL clr_flags got ovf=%b udf=%b cnt=%0d exp 0/0/0", ovf, udf, count); end
    for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 0, 0);
    step(1, 8'h77, 1, 0);
    checks++; if (count !== 5'd16 || ovf !== 1'b0) begin errors++; $display("FAIL fullpp got cnt=%0d ovf=%b exp 16/0", count, ovf); end
    checks++; if (rd_data !== 8'h81) begin errors++; $display("FAIL fullpp_head got %h exp 81", rd_data); end
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rd_data;
      step(0, 8'h00, 1, 0);
    end
    checks++; if (last !== 8'h77) begin errors++; $display("FAIL fullpp_last got %h exp 77", last); end
  endtask

  task automatic test_clear_and_reset();
    for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
    checks++; if (count !== 5'd5 || ovf !== 1'b1) begin errors++; $display("FAIL pre_clr got cnt=%0d ovf=%b exp 5/1", count, ovf); end
    step(1, 8'h99, 0, 1);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL clr_wr got cnt=%0d empty=%b ovf=%b rd=%h exp 0/1/0/00", count, empty, ovf, rd_data); end
    step(1, 8'h3A, 0, 0);
    step(1, 8'h3B, 0, 0);
    checks++; if (count !== 5'd2 || rd_data !== 8'h3A) begin errors++; $display("FAIL post_clr got cnt=%0d rd=%h exp 2/3a", count, rd_data); end
    // Assert reset between edges while a push is pending.
    wr_pulse = 1'b1;
    wr_data  = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL async_rst got cnt=%0d empty=%b rd=%h exp 0/1/00", count, empty, rd_data); end
    @(negedge clk);
    wr_pulse = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++; if (count !== 5'd0 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL rst_release got cnt=%0d ovf=%b udf=%b exp 0/0/0", count, ovf, udf); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_full_push_pop();
    test_clear_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
